game_sequencer: RTL

//  Game-phase controller for the road fighter top level: IDLE -> PLAYING -> CRASH -> RESPAWN/GAMEOVER.

---
 rtl/game_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// Game-phase controller: IDLE -> PLAYING -> CRASH -> RESPAWN/GAMEOVER.
// Owns speed level / scroll period, per-second score, lives and the run enables.
module game_sequencer #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned ACCEL_CYCLES = 100000000,
  parameter int unsigned TOPE_BASE    = 129434,
  parameter int unsigned TOPE_STEP    = 3000,
  parameter int unsigned MAX_LEVEL    = 15,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned CRASH_SECS   = 2
) (
  input  logic        clk,
  input  logic        reset2,
  input  logic        start_n,
  input  logic        colision,
  output logic [2:0]  state,
  output logic        alive,
  output logic        run_en,
  output logic        respawn,
  output logic [3:0]  level,
  output logic [17:0] tope,
  output logic [1:0]  lives,
  output logic [5:0]  score,
  output logic        blink,
  output logic        game_over
);

  localparam int unsigned SEC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned ACC_W   = (ACCEL_CYCLES > 1) ? $clog2(ACCEL_CYCLES) : 1;
  localparam int unsigned CS_W    = $clog2(CRASH_SECS + 1);
  localparam int unsigned SCORE_W = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAYING  = 3'd1,
    CRASH    = 3'd2,
    RESPAWN  = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               start_r1, start_r2;
  logic               start_ev;
  logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic [ACC_W-1:0]   accel_cnt_q, accel_cnt_d;
  logic [CS_W-1:0]    crash_cnt_q, crash_cnt_d;
  logic [3:0]         level_q, level_d;
  logic [17:0]        tope_q, tope_d;
  logic [1:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               blink_q, blink_d;
  logic               sec_run, sec_tick, accel_wrap;

  // Falling edge of the registered start button; a held button fires once.
  assign start_ev = start_r2 & ~start_r1;

  assign sec_run    = (state_q == PLAYING) || (state_q == CRASH);
  assign sec_tick   = sec_run && (sec_cnt_q == SEC_W'(CLK_HZ - 1));
  assign accel_wrap = (state_q == PLAYING) && (accel_cnt_q == ACC_W'(ACCEL_CYCLES - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset2) begin
    if (!reset2) begin
      state_q     <= IDLE;
      start_r1    <= 1'b1;
      start_r2    <= 1'b1;
      sec_cnt_q   <= '0;
      accel_cnt_q <= '0;
      crash_cnt_q <= '0;
      level_q     <= '0;
      tope_q      <= 18'(TOPE_BASE);
      lives_q     <= 2'(LIVES);
      score_q     <= '0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_r1    <= start_n;
      start_r2    <= start_r1;
      sec_cnt_q   <= sec_cnt_d;
      accel_cnt_q <= accel_cnt_d;
      crash_cnt_q <= crash_cnt_d;
      level_q     <= level_d;
      tope_q      <= tope_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      blink_q     <= blink_d;
    end
  end

  // Next-state and next-value logic for every phase.
  always_comb begin
    state_d     = state_q;
    accel_cnt_d = accel_cnt_q;
    crash_cnt_d = crash_cnt_q;
    level_d     = level_q;
    lives_d     = lives_q;
    score_d     = score_q;
    blink_d     = blink_q;
    sec_cnt_d   = '0;
    tope_d      = 18'(TOPE_BASE - 32'(level_q) * TOPE_STEP);

    case (state_q)
      IDLE: begin
        lives_d     = 2'(LIVES);
        score_d     = '0;
        level_d     = '0;
        accel_cnt_d = '0;
        if (start_ev) state_d = PLAYING;
      end
      PLAYING: begin
        if (sec_tick && (score_q != SCORE_W'(63))) score_d = score_q + SCORE_W'(1);
        accel_cnt_d = accel_wrap ? '0 : accel_cnt_q + ACC_W'(1);
        if (accel_wrap && !colision && (level_q != 4'(MAX_LEVEL)))
          level_d = level_q + 4'd1;
        if (colision) state_d = CRASH;
      end
      CRASH: begin
        if (sec_tick) begin
          blink_d     = ~blink_q;
          crash_cnt_d = crash_cnt_q + CS_W'(1);
          if (crash_cnt_q == CS_W'(CRASH_SECS - 1)) begin
            lives_d = lives_q - 2'd1;
            state_d = (lives_q == 2'd1) ? GAMEOVER : RESPAWN;
          end
        end
      end
      RESPAWN: begin
        level_d     = '0;
        accel_cnt_d = '0;
        state_d     = PLAYING;
      end
      GAMEOVER: begin
        if (start_ev) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Prescaler and crash-second counter restart on every phase change.
    if (state_d != state_q) begin
      sec_cnt_d   = '0;
      crash_cnt_d = '0;
    end else if (sec_run) begin
      sec_cnt_d = sec_tick ? '0 : sec_cnt_q + SEC_W'(1);
    end

    if (state_d != CRASH) blink_d = 1'b0;
  end

  // Outputs: registered values plus zero-latency state decodes.
  assign state     = 3'(state_q);
  assign alive     = (state_q == PLAYING);
  assign run_en    = (state_q == PLAYING);
  assign respawn   = (state_q == RESPAWN);
  assign game_over = (state_q == GAMEOVER);
  assign level     = level_q;
  assign tope      = tope_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign blink     = blink_q;

endmodule
